pipe_hazard_unit: RTL and testbench

//  Central hazard/forwarding controller for the parametrised 5-stage RV32 pipeline; replaces the separate stall and forward units.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_fwd_sel.sv | 26 ++
 rtl/pipe_hazard_unit.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;

    // EX operand source select encodings
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    // Multi-cycle EX op tracker states
    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one EX source operand: EX/MEM result beats MEM/WB,
// and x0 is never forwarded.
module hazard_fwd_sel
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);

    // Priority compare against the two younger-result stages
    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Central hazard/forwarding controller for the 5-stage pipeline: load-use
// stall, multi-cycle EX hold, redirect flush, operand forwarding and
// saturating perf counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEFAULT,
    parameter int unsigned MC_LAT     = 4,
    parameter int unsigned KILL_DEPTH = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_AW-1:0]     ex_rs1,
    input  logic [REG_AW-1:0]     ex_rs2,
    input  logic [REG_AW-1:0]     ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_AW-1:0]     mem_rd,
    input  logic                  mem_regwrite,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic                  wb_regwrite,
    input  logic                  ex_redirect,
    input  logic                  ex_mc_start,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  ex_hold,
    output logic [KILL_DEPTH-1:0] flush_vec,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mc_busy,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int unsigned MC_CW = $clog2(MC_LAT);

    mc_state_e        state_q, state_d;
    logic [MC_CW-1:0] cnt_q, cnt_d;

    logic             redir_ok;
    logic             mc_go;
    logic             load_use;
    logic             ld_hazard;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .src          (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a_raw)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .src          (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b_raw)
    );

    // Load-use detection against the load currently in EX
    always_comb begin
        ld_hazard = ex_memread && ex_regwrite && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));
    end

    // Priority resolution and control outputs; everything reads 0 while in reset
    always_comb begin
        redir_ok = rst && ex_redirect && (state_q == MC_IDLE);
        mc_go    = rst && !redir_ok &&
                   ((state_q == MC_BUSY) || ((state_q == MC_IDLE) && ex_mc_start));
        load_use = rst && (state_q == MC_IDLE) && !ex_redirect && !ex_mc_start && ld_hazard;

        pc_stall      = mc_go || load_use;
        if_id_stall   = mc_go || load_use;
        id_ex_bubble  = load_use;
        ex_mem_bubble = mc_go;
        ex_hold       = mc_go;
        mc_busy       = rst && (state_q == MC_BUSY);
        flush_vec     = {KILL_DEPTH{redir_ok}};
        fwd_a         = rst ? fwd_a_raw : FWD_RF;
        fwd_b         = rst ? fwd_b_raw : FWD_RF;
    end

    // Multi-cycle next state: the start cycle plus MC_LAT-2 BUSY cycles form the hold.
    // Leaving BUSY as cnt steps to 0 keeps the hold at MC_LAT-1; MC_LAT==2 needs no BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MC_IDLE: begin
                if (ex_mc_start && !ex_redirect && (MC_LAT > 2)) begin
                    state_d = MC_BUSY;
                    cnt_d   = MC_CW'(MC_LAT - 2);
                end
            end
            MC_BUSY: begin
                cnt_d = cnt_q - MC_CW'(1);
                if (cnt_q == MC_CW'(1)) begin
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating perf counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redir_ok && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: each task queues stimulus rows with
// hand-derived expected controls; the running counter model fills in the
// expected perf counter values.
module tb_pipe_hazard_unit;
    import pipe_pkg::*;

    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_rs1_used, id_rs2_used, ex_regwrite, ex_memread;
    logic          mem_regwrite, wb_regwrite, ex_redirect, ex_mc_start;

    logic        a_pc_stall, a_if_id_stall, a_id_ex_bubble, a_ex_mem_bubble, a_ex_hold, a_mc_busy;
    logic [1:0]  a_flush_vec, a_fwd_a, a_fwd_b;
    logic [31:0] a_stall_cycles, a_flush_events;

    logic        b_pc_stall, b_if_id_stall, b_id_ex_bubble, b_ex_mem_bubble, b_ex_hold, b_mc_busy;
    logic [2:0]  b_flush_vec;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [3:0]  b_stall_cycles, b_flush_events;

    pipe_hazard_unit #(.REG_AW(AW), .MC_LAT(4), .KILL_DEPTH(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
        .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .id_ex_bubble(a_id_ex_bubble),
        .ex_mem_bubble(a_ex_mem_bubble), .ex_hold(a_ex_hold), .flush_vec(a_flush_vec),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .mc_busy(a_mc_busy),
        .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
    );

    pipe_hazard_unit #(.REG_AW(AW), .MC_LAT(4), .KILL_DEPTH(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start),
        .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .id_ex_bubble(b_id_ex_bubble),
        .ex_mem_bubble(b_ex_mem_bubble), .ex_hold(b_ex_hold), .flush_vec(b_flush_vec),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .mc_busy(b_mc_busy),
        .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
    );

    typedef struct packed {
        logic          rst;
        logic [AW-1:0] id_rs1, id_rs2;
        logic          id_rs1_used, id_rs2_used;
        logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
        logic          ex_regwrite, ex_memread;
        logic [AW-1:0] mem_rd;
        logic          mem_regwrite;
        logic [AW-1:0] wb_rd;
        logic          wb_regwrite, ex_redirect, ex_mc_start;
    } in_t;

    typedef struct packed {
        logic       pc, ifid, idex, exmem, hold, busy, flush;
        logic [1:0] fa, fb;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic [1:0]  fl_a;
        logic [2:0]  fl_b;
        logic [31:0] sc_a, fe_a;
        logic [3:0]  sc_b, fe_b;
    } obs_t;

    localparam ctl_t C0    = '0;
    localparam ctl_t CST   = '{pc:1'b1, ifid:1'b1, idex:1'b1, exmem:1'b0, hold:1'b0, busy:1'b0, flush:1'b0, fa:2'b00, fb:2'b00};
    localparam ctl_t CMS   = '{pc:1'b1, ifid:1'b1, idex:1'b0, exmem:1'b1, hold:1'b1, busy:1'b0, flush:1'b0, fa:2'b00, fb:2'b00};
    localparam ctl_t CMB   = '{pc:1'b1, ifid:1'b1, idex:1'b0, exmem:1'b1, hold:1'b1, busy:1'b1, flush:1'b0, fa:2'b00, fb:2'b00};
    localparam ctl_t CFL   = '{pc:1'b0, ifid:1'b0, idex:1'b0, exmem:1'b0, hold:1'b0, busy:1'b0, flush:1'b1, fa:2'b00, fb:2'b00};

    obs_t        sbq[$];
    in_t         rq[$];
    ctl_t        cq[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] xsc_a, xfe_a;
    logic [3:0]  xsc_b, xfe_b;

    function automatic in_t idle_in();
        in_t r;
        r     = '0;
        r.rst = 1'b1;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.c    = '{pc:a_pc_stall, ifid:a_if_id_stall, idex:a_id_ex_bubble, exmem:a_ex_mem_bubble,
                   hold:a_ex_hold, busy:a_mc_busy, flush:a_flush_vec[0], fa:a_fwd_a, fb:a_fwd_b};
        o.fl_a = a_flush_vec;
        o.fl_b = b_flush_vec;
        o.sc_a = a_stall_cycles;
        o.fe_a = a_flush_events;
        o.sc_b = b_stall_cycles;
        o.fe_b = b_flush_events;
        return o;
    endfunction

    task automatic add(input in_t r, input ctl_t c);
        rq.push_back(r);
        cq.push_back(c);
    endtask

    // Drive one row just after the rising edge and queue what it should produce
    task automatic drive_row(input in_t r, input ctl_t c);
        obs_t e;
        @(posedge clk);
        #1;
        rst = r.rst; id_rs1 = r.id_rs1; id_rs2 = r.id_rs2;
        id_rs1_used = r.id_rs1_used; id_rs2_used = r.id_rs2_used;
        ex_rs1 = r.ex_rs1; ex_rs2 = r.ex_rs2; ex_rd = r.ex_rd;
        ex_regwrite = r.ex_regwrite; ex_memread = r.ex_memread;
        mem_rd = r.mem_rd; mem_regwrite = r.mem_regwrite;
        wb_rd = r.wb_rd; wb_regwrite = r.wb_regwrite;
        ex_redirect = r.ex_redirect; ex_mc_start = r.ex_mc_start;
        e.c    = c;
        e.fl_a = {2{c.flush}};
        e.fl_b = {3{c.flush}};
        e.sc_a = xsc_a; e.fe_a = xfe_a; e.sc_b = xsc_b; e.fe_b = xfe_b;
        sbq.push_back(e);
        if (!r.rst) begin
            xsc_a = '0; xfe_a = '0; xsc_b = '0; xfe_b = '0;
        end else begin
            if (c.pc) begin
                xsc_a = xsc_a + 32'd1;
                if (xsc_b != 4'hF) xsc_b = xsc_b + 4'd1;
            end
            if (c.flush) begin
                xfe_a = xfe_a + 32'd1;
                if (xfe_b != 4'hF) xfe_b = xfe_b + 4'd1;
            end
        end
    endtask

    task automatic test_reset();
        in_t r; ctl_t c; obs_t o, e; int k = 0;
        r = idle_in(); r.rst = 1'b0;
        add(r, C0); add(r, C0);
        r.ex_mc_start = 1'b1; r.ex_rs1 = 5'd5; r.mem_rd = 5'd5; r.mem_regwrite = 1'b1;
        add(r, C0);
        add(idle_in(), C0); add(idle_in(), C0);
        while (rq.size() > 0) begin
            r = rq.pop_front(); c = cq.pop_front();
            drive_row(r, c);
            @(negedge clk); o = sample(); e = sbq.pop_front(); n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL reset[%0d]: got %h want %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_forward();
        in_t r; ctl_t c; obs_t o, e; int k = 0;
        r = idle_in(); r.ex_rs1 = 5; r.ex_rs2 = 7; r.mem_rd = 5; r.mem_regwrite = 1;
        c = C0; c.fa = 2'b10; add(r, c);
        r = idle_in(); r.ex_rs1 = 5; r.mem_rd = 3; r.mem_regwrite = 1; r.wb_rd = 5; r.wb_regwrite = 1;
        c = C0; c.fa = 2'b01; add(r, c);
        r = idle_in(); r.ex_rs1 = 0; r.mem_rd = 0; r.mem_regwrite = 1; r.wb_rd = 0; r.wb_regwrite = 1;
        add(r, C0);
        r = idle_in(); r.ex_rs2 = 9; r.mem_rd = 9; r.mem_regwrite = 1; r.wb_rd = 9; r.wb_regwrite = 1;
        c = C0; c.fb = 2'b10; add(r, c);
        r = idle_in(); r.ex_rs1 = 5; r.mem_rd = 5; r.wb_rd = 5; r.wb_regwrite = 1;
        c = C0; c.fa = 2'b01; add(r, c);
        r = idle_in(); r.ex_rs1 = 5; r.mem_rd = 5; r.wb_rd = 5;
        add(r, C0);
        r = idle_in(); r.ex_rs1 = 4; r.ex_rs2 = 4; r.mem_rd = 4; r.mem_regwrite = 1;
        c = C0; c.fa = 2'b10; c.fb = 2'b10; add(r, c);
        r = idle_in(); r.ex_rs1 = 31; r.ex_rs2 = 30; r.mem_rd = 31; r.mem_regwrite = 1; r.wb_rd = 30; r.wb_regwrite = 1;
        c = C0; c.fa = 2'b10; c.fb = 2'b01; add(r, c);
        while (rq.size() > 0) begin
            r = rq.pop_front(); c = cq.pop_front();
            drive_row(r, c);
            @(negedge clk); o = sample(); e = sbq.pop_front(); n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL forward[%0d]: got %h want %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_load_use();
        in_t r; ctl_t c; obs_t o, e; int k = 0;
        r = idle_in(); r.ex_rd = 6; r.ex_memread = 1; r.ex_regwrite = 1; r.id_rs2 = 6; r.id_rs2_used = 1;
        add(r, CST);
        r = idle_in(); r.mem_rd = 6; r.mem_regwrite = 1; r.id_rs2 = 6; r.id_rs2_used = 1;
        add(r, C0);
        r = idle_in(); r.ex_rs2 = 6; r.wb_rd = 6; r.wb_regwrite = 1;
        c = C0; c.fb = 2'b01; add(r, c);
        r = idle_in(); r.ex_rd = 6; r.ex_memread = 1; r.ex_regwrite = 1; r.id_rs2 = 6; r.id_rs1 = 3; r.id_rs1_used = 1;
        add(r, C0);
        r = idle_in(); r.ex_rd = 6; r.ex_memread = 1; r.ex_regwrite = 1; r.id_rs1 = 6; r.id_rs1_used = 1;
        add(r, CST);
        r = idle_in(); r.ex_rd = 0; r.ex_memread = 1; r.ex_regwrite = 1; r.id_rs1 = 0; r.id_rs1_used = 1;
        add(r, C0);
        r = idle_in(); r.ex_rd = 6; r.ex_memread = 1; r.id_rs1 = 6; r.id_rs1_used = 1;
        add(r, C0);
        r = idle_in(); r.ex_rd = 6; r.ex_regwrite = 1; r.id_rs1 = 6; r.id_rs1_used = 1;
        add(r, C0);
        r = idle_in(); r.ex_rd = 8; r.ex_memread = 1; r.ex_regwrite = 1;
        r.id_rs1 = 8; r.id_rs1_used = 1; r.id_rs2 = 8; r.id_rs2_used = 1;
        add(r, CST);
        add(idle_in(), C0);
        while (rq.size() > 0) begin
            r = rq.pop_front(); c = cq.pop_front();
            drive_row(r, c);
            @(negedge clk); o = sample(); e = sbq.pop_front(); n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL load_use[%0d]: got %h want %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_multicycle();
        in_t r, s, h; ctl_t c; obs_t o, e; int k = 0;
        s = idle_in(); s.ex_mc_start = 1;
        h = idle_in(); h.ex_rd = 6; h.ex_memread = 1; h.ex_regwrite = 1; h.id_rs1 = 6; h.id_rs1_used = 1;
        add(idle_in(), C0);
        add(s, CMS); add(idle_in(), CMB); add(idle_in(), CMB); add(idle_in(), C0);
        r = h; r.ex_mc_start = 1; add(r, CMS);
        add(r, CMB);
        add(idle_in(), CMB);
        add(idle_in(), C0);
        while (rq.size() > 0) begin
            r = rq.pop_front(); c = cq.pop_front();
            drive_row(r, c);
            @(negedge clk); o = sample(); e = sbq.pop_front(); n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL multicycle[%0d]: got %h want %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_redirect();
        in_t r; ctl_t c; obs_t o, e; int k = 0;
        r = idle_in(); r.ex_rd = 6; r.ex_memread = 1; r.ex_regwrite = 1; r.id_rs2 = 6; r.id_rs2_used = 1;
        r.ex_redirect = 1; add(r, CFL);
        r = idle_in(); r.ex_redirect = 1; r.ex_mc_start = 1; add(r, CFL);
        add(idle_in(), C0);
        r = idle_in(); r.ex_redirect = 1; add(r, CFL); add(r, CFL);
        add(idle_in(), C0);
        while (rq.size() > 0) begin
            r = rq.pop_front(); c = cq.pop_front();
            drive_row(r, c);
            @(negedge clk); o = sample(); e = sbq.pop_front(); n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL redirect[%0d]: got %h want %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_reset_mid_busy();
        in_t r; ctl_t c; obs_t o, e; int k = 0;
        r = idle_in(); r.ex_mc_start = 1; add(r, CMS);
        add(idle_in(), CMB);
        r = idle_in(); r.rst = 0; add(r, C0);
        add(idle_in(), C0); add(idle_in(), C0);
        while (rq.size() > 0) begin
            r = rq.pop_front(); c = cq.pop_front();
            drive_row(r, c);
            @(negedge clk); o = sample(); e = sbq.pop_front(); n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL reset_mid_busy[%0d]: got %h want %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        in_t r; ctl_t c; obs_t o, e; int k = 0;
        r = idle_in(); r.ex_mc_start = 1;
        add(r, CMS); add(idle_in(), CMB); add(idle_in(), CMB);
        add(r, CMS); add(idle_in(), CMB); add(idle_in(), CMB);
        add(idle_in(), C0);
        while (rq.size() > 0) begin
            r = rq.pop_front(); c = cq.pop_front();
            drive_row(r, c);
            @(negedge clk); o = sample(); e = sbq.pop_front(); n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL back_to_back[%0d]: got %h want %h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_saturation();
        in_t r; ctl_t c; obs_t o, e; int k = 0;
        r = idle_in(); r.ex_rd = 7; r.ex_memread = 1; r.ex_regwrite = 1; r.id_rs1 = 7; r.id_rs1_used = 1;
        for (int i = 0; i < 20; i++) add(r, CST);
        r = idle_in(); r.ex_redirect = 1;
        for (int i = 0; i < 18; i++) add(r, CFL);
        add(idle_in(), C0);
        while (rq.size() > 0) begin
            r = rq.pop_front(); c = cq.pop_front();
            drive_row(r, c);
            @(negedge clk); o = sample(); e = sbq.pop_front(); n_cmp++;
            if (o !== e) begin n_mis++; $display("FAIL saturation[%0d]: got %h want %h", k, o, e); end
            k++;
        end
        n_cmp++;
        if (b_stall_cycles !== 4'hF) begin
            n_mis++; $display("FAIL stall_sat: got %h want f", b_stall_cycles);
        end
        n_cmp++;
        if (b_flush_events !== 4'hF) begin
            n_mis++; $display("FAIL flush_sat: got %h want f", b_flush_events);
        end
    endtask

    // Redirect during a multi-cycle op is outside the legal input space
    always @(negedge clk) begin
        if (rst === 1'b1 && ex_redirect === 1'b1 && a_mc_busy === 1'b1) begin
            n_mis++;
            $display("FAIL redirect_while_busy: got 1 want 0");
        end
    end

    initial begin
        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
        ex_redirect = 1'b0; ex_mc_start = 1'b0;
        xsc_a = '0; xfe_a = '0; xsc_b = '0; xfe_b = '0;
        test_reset();
        test_forward();
        test_load_use();
        test_multicycle();
        test_redirect();
        test_reset_mid_busy();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
